// File: rtl/m3_speed_power_ramp.sv
// Speed/power ramp controller for the 3-phase motor path.
// Owns the ramp tick divider, user speed/power targets and the
// IDLE/RAMP_UP/RUN/RAMP_DOWN/REVERSE state machine. Actual speed and power
// slew toward their goal once per tick; all outputs are registered.
module m3_speed_power_ramp #(
  parameter int CLK_DIV   = 10000,
  parameter int SPD_W     = 8,
  parameter int PWR_W     = 8,
  parameter int SPD_MAX   = 200,
  parameter int SPD_MIN   = 10,
  parameter int PWR_MAX   = 255,
  parameter int PWR_MIN   = 0,
  parameter int TGT_STEP  = 5,
  parameter int RAMP_STEP = 2,
  parameter int SPD_INIT  = 50,
  parameter int PWR_INIT  = 64
) (
  input  logic             clkI,
  input  logic             rstI,
  input  logic             m3startI,
  input  logic             m3stopI,
  input  logic             m3forceStopI,
  input  logic             m3invRotateI,
  input  logic             m3speedINCi,
  input  logic             m3speedDECi,
  input  logic             m3powerINCi,
  input  logic             m3powerDECi,
  output logic             tickO,
  output logic             workingO,
  output logic [SPD_W-1:0] speedO,
  output logic [PWR_W-1:0] powerO,
  output logic             dirO,
  output logic [2:0]       stateO
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RUN       = 3'd2,
    RAMP_DOWN = 3'd3,
    REVERSE   = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // bit positions inside the edge-detect vectors
  localparam int B_START = 0;
  localparam int B_STOP  = 1;
  localparam int B_INV   = 2;
  localparam int B_SINC  = 3;
  localparam int B_SDEC  = 4;
  localparam int B_PINC  = 5;
  localparam int B_PDEC  = 6;

  // Move act toward goal by at most RAMP_STEP.
  function automatic int ramp_toward(input int act, input int goal);
    int d;
    int res;
    if (goal > act) begin
      d   = goal - act;
      res = act + ((d < RAMP_STEP) ? d : RAMP_STEP);
    end else if (goal < act) begin
      d   = act - goal;
      res = act - ((d < RAMP_STEP) ? d : RAMP_STEP);
    end else begin
      res = act;
    end
    return res;
  endfunction

  // Apply one INC/DEC press with saturation; simultaneous presses cancel.
  function automatic int tgt_adjust(input int tgt, input logic inc, input logic dec,
                                    input int lo, input int hi);
    int res;
    if (inc && !dec) begin
      res = (tgt + TGT_STEP > hi) ? hi : tgt + TGT_STEP;
    end else if (dec && !inc) begin
      res = (tgt - TGT_STEP < lo) ? lo : tgt - TGT_STEP;
    end else begin
      res = tgt;
    end
    return res;
  endfunction

  state_t           state_q, state_d;
  logic [6:0]       in_q, in_d, hist_q, hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             working_q, working_d;
  logic             dir_q, dir_d;
  logic [SPD_W-1:0] spd_q, spd_d, spd_tgt_q, spd_tgt_d, spd_next;
  logic [PWR_W-1:0] pwr_q, pwr_d, pwr_tgt_q, pwr_tgt_d, pwr_next;
  logic [6:0]       rise;
  logic             tgt_chg, at_tgt, at_zero;
  int               spd_goal, pwr_goal;

  // Register stage: synchronous reset, otherwise load next-state values.
  always_ff @(posedge clkI) begin
    if (rstI) begin
      state_q   <= IDLE;
      in_q      <= 7'd0;
      hist_q    <= 7'd0;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      working_q <= 1'b0;
      dir_q     <= 1'b0;
      spd_q     <= '0;
      pwr_q     <= '0;
      spd_tgt_q <= SPD_W'(SPD_INIT);
      pwr_tgt_q <= PWR_W'(PWR_INIT);
    end else begin
      state_q   <= state_d;
      in_q      <= in_d;
      hist_q    <= hist_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      working_q <= working_d;
      dir_q     <= dir_d;
      spd_q     <= spd_d;
      pwr_q     <= pwr_d;
      spd_tgt_q <= spd_tgt_d;
      pwr_tgt_q <= pwr_tgt_d;
    end
  end

  // Next-state logic: edge detect, targets, ramp, state machine, divider.
  always_comb begin
    in_d = {m3powerDECi, m3powerINCi, m3speedDECi, m3speedINCi,
            m3invRotateI, m3stopI, m3startI};
    hist_d    = in_q;
    rise      = in_q & ~hist_q;
    state_d   = state_q;
    dir_d     = dir_q;
    spd_tgt_d = spd_tgt_q;
    pwr_tgt_d = pwr_tgt_q;

    // force stop freezes the targets for that cycle
    if (m3forceStopI) begin
      spd_tgt_d = spd_tgt_q;
      pwr_tgt_d = pwr_tgt_q;
    end else begin
      spd_tgt_d = SPD_W'(tgt_adjust(int'(spd_tgt_q), rise[B_SINC], rise[B_SDEC], SPD_MIN, SPD_MAX));
      pwr_tgt_d = PWR_W'(tgt_adjust(int'(pwr_tgt_q), rise[B_PINC], rise[B_PDEC], PWR_MIN, PWR_MAX));
    end
    tgt_chg = (spd_tgt_d != spd_tgt_q) || (pwr_tgt_d != pwr_tgt_q);

    case (state_q)
      RAMP_UP, RUN: begin
        spd_goal = int'(spd_tgt_q);
        pwr_goal = int'(pwr_tgt_q);
      end
      default: begin
        spd_goal = 0;
        pwr_goal = 0;
      end
    endcase

    if (tick_q) begin
      spd_next = SPD_W'(ramp_toward(int'(spd_q), spd_goal));
      pwr_next = PWR_W'(ramp_toward(int'(pwr_q), pwr_goal));
    end else begin
      spd_next = spd_q;
      pwr_next = pwr_q;
    end
    at_tgt  = (spd_next == spd_tgt_q) && (pwr_next == pwr_tgt_q);
    at_zero = (spd_next == '0) && (pwr_next == '0);

    if (m3forceStopI) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise[B_START]) state_d = RAMP_UP;
          else               state_d = IDLE;
        end
        RAMP_UP: begin
          if (rise[B_STOP])                     state_d = RAMP_DOWN;
          else if (rise[B_INV])                 state_d = REVERSE;
          else if (tick_q && at_tgt && !tgt_chg) state_d = RUN;
          else                                  state_d = RAMP_UP;
        end
        RUN: begin
          if (rise[B_STOP])     state_d = RAMP_DOWN;
          else if (rise[B_INV]) state_d = REVERSE;
          else if (tgt_chg)     state_d = RAMP_UP;
          else                  state_d = RUN;
        end
        RAMP_DOWN: begin
          if (rise[B_START])          state_d = RAMP_UP;
          else if (tick_q && at_zero) state_d = IDLE;
          else                        state_d = RAMP_DOWN;
        end
        REVERSE: begin
          if (rise[B_STOP]) begin
            state_d = RAMP_DOWN;
          end else if (tick_q && at_zero) begin
            state_d = RAMP_UP;
            dir_d   = ~dir_q;
          end else begin
            state_d = REVERSE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // IDLE always presents zero speed/power
    if (state_d == IDLE) begin
      spd_d = '0;
      pwr_d = '0;
    end else begin
      spd_d = spd_next;
      pwr_d = pwr_next;
    end

    // divider starts counting on the first cycle spent outside IDLE
    if ((state_d == IDLE) || (state_q == IDLE)) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CNT_ONE;
      tick_d = 1'b0;
    end

    working_d = (state_d != IDLE);
  end

  assign tickO    = tick_q;
  assign workingO = working_q;
  assign speedO   = spd_q;
  assign powerO   = pwr_q;
  assign dirO     = dir_q;
  assign stateO   = state_q;

endmodule

// File: tb/tb_m3_speed_power_ramp.sv
// Directed self-checking bench for m3_speed_power_ramp with a short tick.
module tb_m3_speed_power_ramp;

  localparam logic [6:0] START = 7'b0000001;
  localparam logic [6:0] STOP  = 7'b0000010;
  localparam logic [6:0] INV   = 7'b0000100;
  localparam logic [6:0] SINC  = 7'b0001000;
  localparam logic [6:0] SDEC  = 7'b0010000;

  localparam int S_IDLE = 0, S_UP = 1, S_RUN = 2, S_DOWN = 3, S_REV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] btn;
  logic       force_stop;
  logic       tick, working, dir;
  logic [7:0] speed, power;
  logic [2:0] state;

  int n_vec    = 0;
  int n_bad    = 0;
  int tick_cnt = 0;
  int base;

  always #5 clk = ~clk;

  // running count of tick pulses, used to measure ramp lengths
  always @(posedge clk) if (tick) tick_cnt <= tick_cnt + 1;

  m3_speed_power_ramp #(
    .CLK_DIV(4), .SPD_W(8), .PWR_W(8), .SPD_MAX(20), .SPD_MIN(10),
    .PWR_MAX(255), .PWR_MIN(0), .TGT_STEP(5), .RAMP_STEP(2),
    .SPD_INIT(10), .PWR_INIT(6)
  ) dut (
    .clkI(clk), .rstI(rst),
    .m3startI(btn[0]), .m3stopI(btn[1]), .m3forceStopI(force_stop),
    .m3invRotateI(btn[2]), .m3speedINCi(btn[3]), .m3speedDECi(btn[4]),
    .m3powerINCi(btn[5]), .m3powerDECi(btn[6]),
    .tickO(tick), .workingO(working), .speedO(speed), .powerO(power),
    .dirO(dir), .stateO(state)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one-cycle pulse; on return the resulting state change is visible
  task automatic press(input logic [6:0] m);
    btn = m;
    cyc(1);
    btn = 7'd0;
    cyc(1);
  endtask

  task automatic wait_state(input int st, input int budget, input string tag);
    int i;
    i = 0;
    while (int'(state) != st && i < budget) begin
      cyc(1);
      i++;
    end
    check(tag, int'(state), st);
  endtask

  task automatic wait_speed(input int sp, input int budget, input string tag);
    int i;
    i = 0;
    while (int'(speed) != sp && i < budget) begin
      cyc(1);
      i++;
    end
    check(tag, int'(speed), sp);
  endtask

  initial begin
    rst = 1'b1; btn = 7'd0; force_stop = 1'b0;
    cyc(3);
    check("rst_state", int'(state), S_IDLE);
    check("rst_speed", int'(speed), 0);
    check("rst_power", int'(power), 0);
    check("rst_dir", int'(dir), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_working", int'(working), 0);
    rst = 1'b0;
    cyc(2);
    check("idle_tick", int'(tick), 0);

    // start: first tick CLK_DIV cycles after working rises
    press(START);
    check("start_state", int'(state), S_UP);
    check("start_working", int'(working), 1);
    cyc(3);
    check("tick_early", int'(tick), 0);
    cyc(1);
    check("tick_first", int'(tick), 1);
    cyc(1);
    check("ramp1_speed", int'(speed), 2);
    check("ramp1_power", int'(power), 2);
    check("tick_pulse", int'(tick), 0);
    for (int i = 2; i <= 5; i++) begin
      cyc(4);
      check("ramp_speed", int'(speed), 2 * i);
      check("ramp_power", int'(power), (2 * i < 6) ? 2 * i : 6);
    end
    check("run_state", int'(state), S_RUN);

    // three speed INC presses saturate the target at 20
    press(SINC);
    check("inc_state", int'(state), S_UP);
    base = tick_cnt;
    press(SINC);
    press(SINC);
    wait_state(S_RUN, 100, "inc_run");
    check("inc_speed", int'(speed), 20);
    check("inc_ticks", tick_cnt - base, 5);
    check("inc_power", int'(power), 6);

    // simultaneous INC and DEC: no change
    press(SINC | SDEC);
    check("both_state", int'(state), S_RUN);
    cyc(3);
    check("both_state2", int'(state), S_RUN);
    check("both_speed", int'(speed), 20);

    // two DEC presses re-slew down to 10
    press(SDEC);
    check("dec_state", int'(state), S_UP);
    press(SDEC);
    wait_state(S_RUN, 100, "dec_run");
    check("dec_speed", int'(speed), 10);
    check("dec_power", int'(power), 6);

    // DEC at the lower bound leaves the target and state alone
    press(SDEC);
    check("min_state", int'(state), S_RUN);
    cyc(2);
    check("min_state2", int'(state), S_RUN);

    // reversal through zero
    press(INV);
    check("rev_state", int'(state), S_REV);
    base = tick_cnt;
    wait_state(S_UP, 100, "rev_up");
    check("rev_dir", int'(dir), 1);
    check("rev_speed", int'(speed), 0);
    check("rev_power", int'(power), 0);
    check("rev_ticks", tick_cnt - base, 5);
    wait_state(S_RUN, 100, "rev_run");
    check("rev_run_speed", int'(speed), 10);
    check("rev_run_power", int'(power), 6);
    check("rev_run_dir", int'(dir), 1);

    // stop, then resume from speed 4
    press(STOP);
    check("stop_state", int'(state), S_DOWN);
    wait_speed(4, 100, "down_speed4");
    check("down_state", int'(state), S_DOWN);
    check("down_power", int'(power), 0);
    press(START);
    check("resume_state", int'(state), S_UP);
    check("resume_speed", int'(speed), 4);
    wait_speed(6, 20, "resume_speed6");
    check("resume_power", int'(power), 2);

    // force stop held three cycles
    force_stop = 1'b1;
    cyc(1);
    check("fs_state", int'(state), S_IDLE);
    check("fs_speed", int'(speed), 0);
    check("fs_power", int'(power), 0);
    check("fs_working", int'(working), 0);
    check("fs_dir", int'(dir), 1);
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      check("fs_tick", int'(tick), 0);
      check("fs_hold", int'(state), S_IDLE);
    end
    force_stop = 1'b0;
    cyc(3);
    check("fs_after", int'(state), S_IDLE);

    // restart from zero
    press(START);
    check("restart_state", int'(state), S_UP);
    check("restart_speed", int'(speed), 0);
    wait_speed(2, 20, "restart_speed2");
    check("restart_power", int'(power), 2);
    wait_state(S_RUN, 100, "restart_run");
    check("restart_run_speed", int'(speed), 10);

    // graceful stop all the way to IDLE
    press(STOP);
    check("stop2_state", int'(state), S_DOWN);
    wait_state(S_IDLE, 100, "stop2_idle");
    check("stop2_working", int'(working), 0);
    check("stop2_speed", int'(speed), 0);
    check("stop2_power", int'(power), 0);
    check("stop2_dir", int'(dir), 1);
    base = tick_cnt;
    cyc(8);
    check("idle_silent", tick_cnt - base, 0);

    // reset mid-ramp with start held
    press(START);
    cyc(6);
    check("pre_rst_state", int'(state), S_UP);
    rst = 1'b1;
    btn = START;
    cyc(1);
    check("mrst_state", int'(state), S_IDLE);
    check("mrst_speed", int'(speed), 0);
    check("mrst_power", int'(power), 0);
    check("mrst_dir", int'(dir), 0);
    check("mrst_tick", int'(tick), 0);
    check("mrst_working", int'(working), 0);
    rst = 1'b0;
    btn = 7'd0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/m3_speed_power_ramp.md
# m3_speed_power_ramp

Parametrised speed/power ramp controller for the 3-phase motor path, successor to the fixed 100 Hz speed/power calculator. It owns the internal tick divider, user speed/power targets, and a run/ramp/reverse state machine. Actual speed and power slew toward their targets once per tick, with graceful stop and direction reversal through zero. Outputs feed the commutation and PWM stages.

## Interface
- CLK_DIV, 10000: system clocks per ramp tick (1 MHz → 100 Hz); ≥2
- SPD_W, 8: width of speed target/actual
- PWR_W, 8: width of power target/actual
- SPD_MAX, 200: speed target upper saturation; SPD_MIN, 10: lower saturation
- PWR_MAX, 255: power target upper saturation; PWR_MIN, 0: lower saturation
- TGT_STEP, 5: target change per INC/DEC press (speed and power)
- RAMP_STEP, 2: max actual change per tick
- SPD_INIT, 50 / PWR_INIT, 64: target values after reset
- clkI  in  1  system clock; only clock
- rstI  in  1  synchronous, active-high reset
- m3startI  in  1  start request (rising-edge acted)
- m3stopI  in  1  graceful stop (rising-edge acted)
- m3forceStopI  in  1  immediate stop (level, highest priority)
- m3invRotateI  in  1  reversal request (rising-edge acted)
- m3speedINCi / m3speedDECi  in  1 each  speed target ± TGT_STEP (rising-edge acted)
- m3powerINCi / m3powerDECi  in  1 each  power target ± TGT_STEP (rising-edge acted)
- tickO  out  1  one-cycle pulse per ramp tick
- workingO  out  1  high in any state other than IDLE
- speedO  out  SPD_W  actual speed; powerO  out  PWR_W  actual power
- dirO  out  1  rotation direction (0 forward)
- stateO  out  3  encoded state: IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, REVERSE=4

## Operation
- Edge-acted inputs: previous-cycle sample registered; rising edge = current 1, previous 0. Held levels act once.
- Targets: INC adds TGT_STEP, DEC subtracts, saturating to [MIN, MAX] in width+1 arithmetic; INC and DEC edges same cycle → no change. Targets adjustable in every state, including IDLE.
- Divider: counter 0..CLK_DIV-1 runs only while workingO; tickO=1 when counter==CLK_DIV-1, then wraps to 0. Counter forced to 0 in IDLE.
- On tick, ramp rule: actual moves toward its goal by min(RAMP_STEP, |goal−actual|). Goal = target in RAMP_UP/RUN; goal = 0 in RAMP_DOWN/REVERSE.
- IDLE: speedO=powerO=0. start edge → RAMP_UP. Other edges except targets ignored.
- RAMP_UP: speed and power ramp to targets; when both equal targets at a tick → RUN.
- RUN: target change → RAMP_UP (re-slew either direction). stop edge → RAMP_DOWN. invRotate edge → REVERSE.
- RAMP_DOWN: ramp both to 0; at tick where both reach 0 → IDLE. start edge here → RAMP_UP (resume).
- REVERSE: ramp both to 0; tick where both reach 0 → toggle dirO, → RAMP_UP. Stop edge in REVERSE → RAMP_DOWN, dirO unchanged. invRotate edge in RAMP_UP → REVERSE; in REVERSE/RAMP_DOWN/IDLE ignored.
- start edge in RAMP_UP/RUN/REVERSE ignored.
- m3forceStopI=1: next cycle state=IDLE, speedO=powerO=0, divider cleared, dirO and targets kept; overrides every other input that cycle and holds IDLE while asserted.
- Priority in one cycle: forceStop > stop > invRotate > start.

## Timing
- Reset (rstI high at posedge): state IDLE, speedO=0, powerO=0, dirO=0, tickO=0, workingO=0, divider 0, targets = SPD_INIT/PWR_INIT, edge-detect history 0.
- Input sampled high at posedge k (low at k−1) → state/target change visible after posedge k+1 (one register stage for edge detect).
- First tickO after entering RAMP_UP from IDLE: CLK_DIV cycles after workingO rises.
- speedO/powerO update only on the posedge following a tickO-high cycle; all outputs registered, no combinational paths from inputs.
- Reset mid-ramp: all above reset values next cycle, regardless of other inputs.

## Test plan
- Reset then start, CLK_DIV=4, RAMP_STEP=2, SPD_INIT=10, PWR_INIT=6: speed 2,4,..10 and power 2,4,6 at successive ticks every 4 cycles; RUN after speed hits 10.
- In RUN speed 10: three speedINC pulses (TGT_STEP=5, SPD_MAX=20) → target saturates 20; RAMP_UP; speed reaches 20 after 5 ticks; RUN.
- Both speedINC and speedDEC rising same cycle → target unchanged, state unchanged.
- RUN speed 10, invRotate pulse → REVERSE; speed to 0 over 5 ticks; dirO 0→1 at that tick; RAMP_UP back to 10 with dirO=1.
- Mid RAMP_UP speed 6: forceStop held 3 cycles → IDLE next cycle, speedO=powerO=0, tickO silent, dirO kept; later start restarts from 0.
- RUN, stop pulse → RAMP_DOWN to 0 → IDLE, workingO low; start during RAMP_DOWN at speed 4 → RAMP_UP from 4.
